// File: rtl/uart_rx_axis.sv
// uart_rx_axis: oversampled UART receiver with error detection feeding an AXI4-Stream FIFO
module uart_rx_axis #(
  parameter int    CLK_FREQ   = 50_000_000,
  parameter int    BAUD       = 115200,
  parameter int    DATA_BITS  = 8,
  parameter string PARITY     = "even",
  parameter int    STOP_BITS  = 1,
  parameter int    OVERSAMPLE = 16,
  parameter int    FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          parity_error,
  output logic                          framing_error,
  output logic                          break_det,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam bit HAS_PAR = PARITY != "none";
  localparam bit ODD = PARITY == "odd";
  localparam logic [SW-1:0] S_LO = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_MD = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_HI = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  if (DIV < 1) begin : g_div_chk
    $error("uart_rx_axis: CLK_FREQ too low for BAUD*OVERSAMPLE");
  end
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic [TW-1:0] tick_cnt;
  logic [SW-1:0] s;
  logic [BW-1:0] bc;
  logic [1:0] v;
  logic [DATA_BITS-1:0] data;
  logic p, sbad;
  logic rxs, tick, mid, wrap, vote, sb, pbad, brk, push_req, push_ok, pop, full;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr, rd, rd_n;
  assign rxs = sync[1];
  assign tick = tick_cnt == TW'(DIV - 1);
  assign mid = tick && s == S_HI;
  assign wrap = tick && s == S_END;
  assign vote = (v[0] & v[1]) | (rxs & (v[0] | v[1]));
  assign sb = sbad | ~vote;
  assign pbad = HAS_PAR && (p ^ (^data) ^ ODD);
  assign brk = data == '0 && !(HAS_PAR && p) && sb;
  assign pop = m_axis_tvalid && m_axis_tready;
  assign full = fifo_level == (AW+1)'(FIFO_DEPTH);
  assign push_ok = push_req && (!full || pop);
  assign overrun = push_req && full && !pop;
  assign fifo_level = wr - rd;
  assign m_axis_tvalid = fifo_level != '0;
  assign rd_n = rd + (AW+1)'(pop);
  // FSM state register; reset mid-frame simply abandons the frame
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // Next-state and pulse decode; frame verdict is taken at mid-bit of the last stop bit
  always_comb begin
    state_n = state;
    push_req = 1'b0;
    parity_error = 1'b0;
    framing_error = 1'b0;
    break_det = 1'b0;
    case (state)
      IDLE:  state_n = rxs ? IDLE : START;
      START: state_n = (mid && vote) ? IDLE : wrap ? DATA : START;
      DATA:  state_n = (wrap && bc == BW'(DATA_BITS - 1)) ? (HAS_PAR ? PAR : STOP) : DATA;
      PAR:   state_n = wrap ? STOP : PAR;
      STOP:
        if (mid && bc == BW'(STOP_BITS - 1)) begin
          state_n = brk ? BRK : IDLE;
          break_det = brk;
          framing_error = !brk && sb;
          parity_error = !sb && pbad;
          push_req = !sb && !pbad;
        end
      BRK:   state_n = rxs ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
  // Synchroniser, frame-aligned tick/sample counters and bit-level datapath
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= 2'b11;
      tick_cnt <= '0;
      s <= '0;
      bc <= '0;
      v <= '0;
      data <= '0;
      p <= 1'b0;
      sbad <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      if (state == IDLE && !rxs) begin
        tick_cnt <= '0;
        s <= '0;
        bc <= '0;
        sbad <= 1'b0;
      end else begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) s <= wrap ? '0 : s + 1'b1;
        if (tick && s == S_LO) v[0] <= rxs;
        if (tick && s == S_MD) v[1] <= rxs;
        if (mid && state == DATA) data <= {vote, data[DATA_BITS-1:1]};
        if (mid && state == PAR) p <= vote;
        if (mid && state == STOP) sbad <= sb;
        if (wrap) bc <= state_n != state ? '0 : bc + 1'b1;
      end
    end
  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk)
    if (push_ok) mem[wr[AW-1:0]] <= data;
  // FIFO pointers and registered head word, looking ahead to the post-update head
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr <= '0;
      rd <= '0;
      m_axis_tdata <= '0;
    end else begin
      wr <= wr + (AW+1)'(push_ok);
      rd <= rd_n;
      if (rd_n != wr) m_axis_tdata <= mem[rd_n[AW-1:0]];
      else if (push_ok) m_axis_tdata <= data;
    end
endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: directed UART frames with a scoreboard of expected AXIS words
module tb_uart_rx_axis;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, m_axis_tready = 1'b1;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid, parity_error, framing_error, break_det, overrun;
  logic [2:0] fifo_level;
  int checks = 0, errors = 0;
  int n_pe = 0, n_fe = 0, n_bd = 0, n_ov = 0, n_pop = 0, n_vc = 0, vc0;
  logic [7:0] q[$];
  logic [8:0] exp_w;

  always #5 clk = ~clk;

  uart_rx_axis #(.CLK_FREQ(1_843_200), .BAUD(115200), .DATA_BITS(8), .PARITY("even"),
                 .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx(rx), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .parity_error(parity_error), .framing_error(framing_error),
    .break_det(break_det), .overrun(overrun), .fifo_level(fifo_level));

  // monitor: count pulses and check every accepted word against the scoreboard
  always @(negedge clk)
    if (!rst) begin
      n_pe += int'(parity_error);
      n_fe += int'(framing_error);
      n_bd += int'(break_det);
      n_ov += int'(overrun);
      if (m_axis_tvalid) n_vc++;
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        exp_w = q.size() != 0 ? {1'b0, q.pop_front()} : 9'h100;
        assert ({1'b0, m_axis_tdata} === exp_w)
          else begin errors++; $error("FAIL axis_pop got %h expected %h", m_axis_tdata, exp_w); end
        n_pop++;
      end
    end

  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp)
      else begin errors++; $error("FAIL %s got %0d expected %0d", tag, got, exp); end
  endtask

  task automatic bitx(logic b);
    rx = b;
    repeat (16) @(posedge clk);
    #1;
  endtask

  task automatic frame(logic [7:0] d, logic p, logic s);
    bitx(1'b0);
    for (int i = 0; i < 8; i++) bitx(d[i]);
    bitx(p);
    bitx(s);
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic good(logic [7:0] d);
    q.push_back(d);
    frame(d, ^d, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", int'(m_axis_tvalid), 0);
    chk("rst_tdata", int'(m_axis_tdata), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_pulses", int'(parity_error) + int'(framing_error) + int'(break_det) + int'(overrun), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vc0 = n_vc;
    good(8'hA5);
    chk("t1_pop", n_pop, 1);
    chk("t1_valid_cycles", n_vc - vc0, 1);
    chk("t1_no_err", n_pe + n_fe + n_bd + n_ov, 0);
    frame(8'hA5, 1'b1, 1'b1);
    chk("t2_parity_err", n_pe, 1);
    chk("t2_level", int'(fifo_level), 0);
    chk("t2_pop", n_pop, 1);
    frame(8'h3C, 1'b0, 1'b0);
    chk("t3_framing_err", n_fe, 1);
    good(8'h3C);
    chk("t3_pop", n_pop, 2);
    rx = 1'b0;
    repeat (528) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("t4_break", n_bd, 1);
    chk("t4_no_fe", n_fe, 1);
    chk("t4_pop", n_pop, 2);
    good(8'h55);
    chk("t4_after_pop", n_pop, 3);
    good(8'h00);
    good(8'hFF);
    chk("edge_pop", n_pop, 5);
    chk("edge_break", n_bd, 1);
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) q.push_back(8'(i));
      frame(8'(i), ^(8'(i)), 1'b1);
    end
    chk("t5_level", int'(fifo_level), 4);
    chk("t5_overrun", n_ov, 1);
    chk("t5_tvalid", int'(m_axis_tvalid), 1);
    chk("t5_head", int'(m_axis_tdata), 1);
    m_axis_tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_drained", n_pop, 9);
    chk("t5_level_empty", int'(fifo_level), 0);
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("t6_glitch_pulses", n_pe + n_fe + n_bd + n_ov, 4);
    chk("t6_glitch_tvalid", int'(m_axis_tvalid), 0);
    bitx(1'b0);
    bitx(1'b1);
    bitx(1'b0);
    bitx(1'b1);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_rst_tdata", int'(m_axis_tdata), 0);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("t6_rst_pulses", n_pe + n_fe + n_bd + n_ov, 4);
    chk("t6_rst_pop", n_pop, 9);
    chk("t6_rst_tvalid", int'(m_axis_tvalid), 0);
    good(8'h0F);
    chk("t6_next_pop", n_pop, 10);
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    errors++;
    $error("FAIL timeout got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
